// File: rtl/sum_collector_pkg.sv
// -----------------------------------------------------------------------------
// sum_collector_pkg
//   Shared types and helpers for the sum_collector batching stage.
//   - collector_state_t : batch FSM states (ACCUM collects, HOLD presents total)
//   - cnt_width()       : width of the per-batch sample counter
// -----------------------------------------------------------------------------
package sum_collector_pkg;

    typedef enum logic {
        ACCUM,
        HOLD
    } collector_state_t;

    // Counter only has to reach NUM_SAMPLES-1, so clog2 bits suffice.
    // Clamped to one bit so degenerate values still give a legal vector.
    function automatic int cnt_width(input int num_samples);
        if (num_samples <= 2) begin
            return 1;
        end
        return $clog2(num_samples);
    endfunction

endpackage : sum_collector_pkg

// File: rtl/sum_collector_if.sv
// -----------------------------------------------------------------------------
// sum_collector_if
//   Handshake bundle between the adder stage, the collector and the consumer
//   of batch totals.
//   Input side : in_valid, in_ready, carry, sum[BITS-1:0], flush
//   Output side: out_valid, out_ready, out_total[ACC_BITS-1:0], out_overflow
//   modport master : the environment (drives samples, accepts totals)
//   modport slave  : the collector itself
// -----------------------------------------------------------------------------
interface sum_collector_if #(
    parameter int BITS     = 4,
    parameter int ACC_BITS = 8
);

    logic                in_valid;
    logic                in_ready;
    logic                carry;
    logic [BITS-1:0]     sum;
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    logic [ACC_BITS-1:0] out_total;
    logic                out_overflow;

    modport master (
        output in_valid,
        output carry,
        output sum,
        output flush,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_total,
        input  out_overflow
    );

    modport slave (
        input  in_valid,
        input  carry,
        input  sum,
        input  flush,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_total,
        output out_overflow
    );

endinterface : sum_collector_if

// File: rtl/sum_collector_sat_accumulate.sv
// -----------------------------------------------------------------------------
// sat_accumulate
//   Combinational saturating add of one (BITS+1)-bit unsigned sample into an
//   ACC_BITS-wide unsigned accumulator.
//   Ports:
//     acc_i       [ACC_BITS-1:0]  current accumulator value
//     sample_i    [BITS:0]        {carry, sum} sample, zero-extended
//     next_acc_o  [ACC_BITS-1:0]  saturated acc_i + sample_i
//     ovf_hit_o                   true sum did not fit in ACC_BITS
// -----------------------------------------------------------------------------
module sat_accumulate #(
    parameter int BITS     = 4,
    parameter int ACC_BITS = 8
) (
    input  logic [ACC_BITS-1:0] acc_i,
    input  logic [BITS:0]       sample_i,
    output logic [ACC_BITS-1:0] next_acc_o,
    output logic                ovf_hit_o
);

    localparam int SUM_W = ACC_BITS + 1;

    logic [SUM_W-1:0] raw_sum;

    // One extra bit catches the carry out of the accumulator width.
    assign raw_sum    = {1'b0, acc_i} + SUM_W'(sample_i);
    assign ovf_hit_o  = raw_sum[ACC_BITS];
    assign next_acc_o = ovf_hit_o ? {ACC_BITS{1'b1}} : raw_sum[ACC_BITS-1:0];

endmodule : sat_accumulate

// File: rtl/sum_collector.sv
// -----------------------------------------------------------------------------
// sum_collector
//   Collects NUM_SAMPLES {carry, sum} results from the adder stage into a
//   saturating ACC_BITS accumulator and presents the batch total on a
//   valid/ready port. While a total is pending no new samples are taken.
//   Ports:
//     clock  : rising-edge clock
//     reset  : asynchronous, active-high reset
//     bus    : sum_collector_if.slave
//              in_valid/in_ready/carry/sum/flush  - sample input side
//              out_valid/out_ready/out_total/out_overflow - batch output side
// -----------------------------------------------------------------------------
module sum_collector
    import sum_collector_pkg::*;
#(
    parameter int BITS        = 4,
    parameter int NUM_SAMPLES = 8,
    parameter int ACC_BITS    = 8
) (
    input  logic           clock,
    input  logic           reset,
    sum_collector_if.slave bus
);

    localparam int CNT_W = cnt_width(NUM_SAMPLES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SAMPLES - 1);

    generate
        if (ACC_BITS < BITS + 1) begin : g_bad_acc_bits
            $fatal(1, "sum_collector: ACC_BITS (%0d) must be at least BITS+1 (%0d)",
                   ACC_BITS, BITS + 1);
        end
        if (NUM_SAMPLES < 2) begin : g_bad_num_samples
            $fatal(1, "sum_collector: NUM_SAMPLES (%0d) must be at least 2",
                   NUM_SAMPLES);
        end
    endgenerate

    collector_state_t    state_q, state_d;
    logic [ACC_BITS-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic                out_valid_q, out_valid_d;
    logic [ACC_BITS-1:0] out_total_q, out_total_d;
    logic                out_ovf_q, out_ovf_d;

    logic [BITS:0]       sample;
    logic [ACC_BITS-1:0] sat_acc;
    logic                sat_ovf;
    logic                in_ready;
    logic                accept;
    logic                release_xfer;
    logic                last_sample;

    assign sample       = {bus.carry, bus.sum};
    assign in_ready     = (state_q == ACCUM) && !bus.flush;
    assign accept       = bus.in_valid && in_ready;
    assign release_xfer = out_valid_q && bus.out_ready;
    assign last_sample  = (cnt_q == LAST_CNT);

    sat_accumulate #(
        .BITS     (BITS),
        .ACC_BITS (ACC_BITS)
    ) u_sat_accumulate (
        .acc_i      (acc_q),
        .sample_i   (sample),
        .next_acc_o (sat_acc),
        .ovf_hit_o  (sat_ovf)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_total_d = out_total_q;
        out_ovf_d   = out_ovf_q;

        case (state_q)
            ACCUM: begin
                if (bus.flush) begin
                    acc_d = '0;
                    cnt_d = '0;
                    ovf_d = 1'b0;
                end else if (accept) begin
                    acc_d = sat_acc;
                    // Sticky: once saturated, acc is all-ones so any further
                    // nonzero sample re-hits, and a zero sample keeps the flag.
                    ovf_d = ovf_q | sat_ovf;
                    if (last_sample) begin
                        // Counter is left at its last value; the release
                        // clears it, so it never wraps by overflow.
                        state_d     = HOLD;
                        out_valid_d = 1'b1;
                        out_total_d = sat_acc;
                        out_ovf_d   = ovf_q | sat_ovf;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            HOLD: begin
                if (release_xfer) begin
                    state_d     = ACCUM;
                    acc_d       = '0;
                    cnt_d       = '0;
                    ovf_d       = 1'b0;
                    out_valid_d = 1'b0;
                    out_total_d = '0;
                    out_ovf_d   = 1'b0;
                end
            end

            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_total_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_total_q <= out_total_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_total    = out_total_q;
    assign bus.out_overflow = out_ovf_q;

endmodule : sum_collector

// File: tb/tb_sum_collector.sv
module tb_sum_collector;
    import sum_collector_pkg::*;

    localparam int BITS   = 4;
    localparam int N      = 8;
    localparam int ACC_W  = 8;
    localparam int ACC_W7 = 7;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    sum_collector_if #(.BITS(BITS), .ACC_BITS(ACC_W))  bus  ();
    sum_collector_if #(.BITS(BITS), .ACC_BITS(ACC_W7)) bus7 ();

    sum_collector #(.BITS(BITS), .NUM_SAMPLES(N), .ACC_BITS(ACC_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    sum_collector #(.BITS(BITS), .NUM_SAMPLES(N), .ACC_BITS(ACC_W7)) dut7 (
        .clock (clock),
        .reset (reset),
        .bus   (bus7.slave)
    );

    typedef struct {
        int total;
        bit ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model of the default-width instance
    int m_acc;
    int m_cnt;
    bit m_ovf;
    bit m_hold;

    function automatic int sat_add(input int acc, input int sample, input int w, output bit hit);
        int lim;
        int s;
        lim = (1 << w) - 1;
        s   = acc + sample;
        hit = (s > lim);
        return hit ? lim : s;
    endfunction

    task automatic model_reset();
        m_acc  = 0;
        m_cnt  = 0;
        m_ovf  = 0;
        m_hold = 0;
    endtask

    // Drives one cycle of stimulus on both instances starting at a falling
    // edge, records in_ready before the rising edge, updates the model at the
    // rising edge and returns at the next falling edge.
    task automatic drive(input bit v, input bit c, input int s, input bit fl,
                         input bit ordy, output bit rdy_seen);
        bit   acc_ok;
        bit   rel;
        bit   hit;
        int   smp;
        exp_t e;
        bus.in_valid   = v;    bus7.in_valid  = v;
        bus.carry      = c;    bus7.carry     = c;
        bus.sum        = s[BITS-1:0];
        bus7.sum       = s[BITS-1:0];
        bus.flush      = fl;   bus7.flush     = fl;
        bus.out_ready  = ordy; bus7.out_ready = ordy;
        #1 rdy_seen = bus.in_ready;
        acc_ok = v && !m_hold && !fl;
        rel    = m_hold && ordy;
        smp    = (int'(c) << BITS) + (s & ((1 << BITS) - 1));
        @(posedge clock);
        if (rel) begin
            model_reset();
        end else if (!m_hold && fl) begin
            m_acc = 0;
            m_cnt = 0;
            m_ovf = 0;
        end else if (acc_ok) begin
            m_acc = sat_add(m_acc, smp, ACC_W, hit);
            m_ovf = m_ovf | hit;
            m_cnt++;
            if (m_cnt == N) begin
                m_hold  = 1;
                e.total = m_acc;
                e.ovf   = m_ovf;
                exp_q.push_back(e);
            end
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        bus.in_valid  = 0; bus7.in_valid  = 0;
        bus.carry     = 0; bus7.carry     = 0;
        bus.sum       = '0; bus7.sum      = '0;
        bus.flush     = 0; bus7.flush     = 0;
        bus.out_ready = 0; bus7.out_ready = 0;
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        exp_q.delete();
        n_tests++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        end
        n_tests++;
        if (bus.out_total !== 8'd0) begin
            n_fail++; $display("FAIL reset_out_total: got %0d expected 0", bus.out_total);
        end
        n_tests++;
        if (bus.out_overflow !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_overflow: got %b expected 0", bus.out_overflow);
        end
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
    endtask

    task automatic test_basic();
        bit   r;
        exp_t e;
        for (int i = 0; i < N; i++) begin
            drive(1, 0, 3, 0, 1, r);
            n_tests++;
            if (r !== 1'b1) begin
                n_fail++; $display("FAIL basic_in_ready[%0d]: got %b expected 1", i, r);
            end
            if (i == N - 2) begin
                n_tests++;
                if (bus.out_valid !== 1'b0) begin
                    n_fail++; $display("FAIL basic_early_valid: got %b expected 0", bus.out_valid);
                end
            end
        end
        n_tests++;
        if (bus.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL basic_valid_latency: got %b expected 1", bus.out_valid);
        end
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL basic_scoreboard: got empty queue expected 1 entry");
        end else begin
            e = exp_q.pop_front();
            if (bus.out_total !== e.total[ACC_W-1:0] || bus.out_overflow !== e.ovf) begin
                n_fail++; $display("FAIL basic_total: got %0d/%b expected %0d/%b",
                                   bus.out_total, bus.out_overflow, e.total, e.ovf);
            end
        end
        drive(0, 0, 0, 0, 1, r);
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL basic_release: got valid=%b ready=%b expected valid=0 ready=1",
                               bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_saturate();
        bit   r;
        bit   hit;
        int   a7;
        bit   o7;
        exp_t e;
        a7 = 0;
        o7 = 0;
        for (int i = 0; i < N; i++) begin
            drive(1, 1, 15, 0, 0, r);
            a7 = sat_add(a7, 31, ACC_W7, hit);
            o7 = o7 | hit;
        end
        n_tests++;
        if (exp_q.size() == 0 || bus.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL sat_valid: got valid=%b queue=%0d expected valid=1 queue=1",
                               bus.out_valid, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            if (bus.out_total !== e.total[ACC_W-1:0] || bus.out_overflow !== e.ovf) begin
                n_fail++; $display("FAIL sat_total_w8: got %0d/%b expected %0d/%b",
                                   bus.out_total, bus.out_overflow, e.total, e.ovf);
            end
        end
        n_tests++;
        if (bus7.out_valid !== 1'b1 || bus7.out_total !== a7[ACC_W7-1:0] || bus7.out_overflow !== o7) begin
            n_fail++; $display("FAIL sat_total_w7: got %b/%0d/%b expected 1/%0d/%b",
                               bus7.out_valid, bus7.out_total, bus7.out_overflow, a7, o7);
        end
        drive(0, 0, 0, 0, 1, r);
    endtask

    task automatic test_hold();
        bit   r;
        exp_t e;
        e.total = -1;
        e.ovf   = 0;
        for (int i = 0; i < N; i++) begin
            drive(1, 0, 2, 0, 0, r);
        end
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL hold_scoreboard: got empty queue expected 1 entry");
        end else begin
            e = exp_q.pop_front();
        end
        for (int k = 0; k < 5; k++) begin
            drive((k % 2) == 0, 0, 1, 0, 0, r);
            n_tests++;
            if (r !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_total !== e.total[ACC_W-1:0]) begin
                n_fail++; $display("FAIL hold_stable[%0d]: got ready=%b valid=%b total=%0d expected 0/1/%0d",
                                   k, r, bus.out_valid, bus.out_total, e.total);
            end
        end
        drive(0, 0, 0, 0, 1, r);
        for (int i = 0; i < N; i++) begin
            drive(1, 0, 1, 0, 1, r);
        end
        n_tests++;
        if (exp_q.size() == 0 || bus.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL hold_next_valid: got valid=%b queue=%0d expected 1/1",
                               bus.out_valid, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            if (bus.out_total !== e.total[ACC_W-1:0]) begin
                n_fail++; $display("FAIL hold_next_total: got %0d expected %0d", bus.out_total, e.total);
            end
        end
        drive(0, 0, 0, 0, 1, r);
    endtask

    task automatic test_alternate();
        bit   r;
        exp_t e;
        for (int i = 0; i < 2 * N - 1; i++) begin
            drive((i % 2) == 0, 0, 5, 0, 1, r);
            if (i == 2 * N - 4) begin
                n_tests++;
                if (bus.out_valid !== 1'b0) begin
                    n_fail++; $display("FAIL alt_early_valid: got %b expected 0", bus.out_valid);
                end
            end
        end
        n_tests++;
        if (exp_q.size() == 0 || bus.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL alt_valid: got valid=%b queue=%0d expected 1/1",
                               bus.out_valid, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            if (bus.out_total !== e.total[ACC_W-1:0] || bus.out_overflow !== e.ovf) begin
                n_fail++; $display("FAIL alt_total: got %0d/%b expected %0d/%b",
                                   bus.out_total, bus.out_overflow, e.total, e.ovf);
            end
        end
        drive(0, 0, 0, 0, 1, r);
    endtask

    task automatic test_flush();
        bit   r;
        exp_t e;
        e.total = -1;
        e.ovf   = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 7, 0, 1, r);
        end
        drive(1, 0, 7, 1, 1, r);
        n_tests++;
        if (r !== 1'b0) begin
            n_fail++; $display("FAIL flush_in_ready: got %b expected 0", r);
        end
        for (int i = 0; i < N; i++) begin
            drive(1, 0, 1, 0, 0, r);
        end
        n_tests++;
        if (exp_q.size() == 0 || bus.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL flush_valid: got valid=%b queue=%0d expected 1/1",
                               bus.out_valid, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            if (bus.out_total !== e.total[ACC_W-1:0]) begin
                n_fail++; $display("FAIL flush_total: got %0d expected %0d", bus.out_total, e.total);
            end
        end
        // flush while a total is pending must not disturb it
        drive(0, 0, 0, 1, 0, r);
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_total !== e.total[ACC_W-1:0]) begin
            n_fail++; $display("FAIL flush_in_hold: got valid=%b total=%0d expected 1/%0d",
                               bus.out_valid, bus.out_total, e.total);
        end
        drive(0, 0, 0, 0, 1, r);
    endtask

    task automatic test_async_reset();
        bit   r;
        exp_t e;
        // Reset while a total is pending: it must vanish before the next edge.
        for (int i = 0; i < N; i++) begin
            drive(1, 0, 9, 0, 0, r);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
        end
        n_tests++;
        if (bus.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL areset_pending: got %b expected 1", bus.out_valid);
        end
        bus.in_valid = 0; bus7.in_valid = 0;
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.out_total !== 8'd0 || bus.out_overflow !== 1'b0) begin
            n_fail++; $display("FAIL areset_hold: got %b/%0d/%b expected 0/0/0",
                               bus.out_valid, bus.out_total, bus.out_overflow);
        end
        reset = 1'b0;
        model_reset();
        @(negedge clock);

        // Reset mid-batch: the partial sum is lost.
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 9, 0, 1, r);
        end
        bus.in_valid = 0; bus7.in_valid = 0;
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.out_total !== 8'd0 || bus.out_overflow !== 1'b0) begin
            n_fail++; $display("FAIL areset_mid: got %b/%0d/%b expected 0/0/0",
                               bus.out_valid, bus.out_total, bus.out_overflow);
        end
        reset = 1'b0;
        model_reset();
        @(negedge clock);
        for (int i = 0; i < N; i++) begin
            drive(1, 0, 2, 0, 0, r);
        end
        n_tests++;
        if (exp_q.size() == 0 || bus.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL areset_after_valid: got valid=%b queue=%0d expected 1/1",
                               bus.out_valid, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            if (bus.out_total !== e.total[ACC_W-1:0]) begin
                n_fail++; $display("FAIL areset_after_total: got %0d expected %0d", bus.out_total, e.total);
            end
        end
        drive(0, 0, 0, 0, 1, r);
    endtask

    initial begin
        reset = 1'b1;
        @(negedge clock);
        test_reset();
        test_basic();
        test_saturate();
        test_hold();
        test_alternate();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_sum_collector

// File: doc/sum_collector.md
Name: sum_collector

Overview:
Downstream consumer of the 4-bit adder stage. Accepts one {carry, sum} result per handshake, accumulates NUM_SAMPLES results into a wider saturating accumulator, then presents the total on a valid/ready output port. Used to batch adder results before they are handed to the next stage.

Parameters:
BITS, 4, width of the adder sum input; the carry extends each sample to BITS+1 bits.
NUM_SAMPLES, 8, samples per batch; legal range is 2 or more.
ACC_BITS, 8, accumulator and output width; must be at least BITS+1.

Ports:
clock  input  1  single clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  the carry/sum pair is valid this cycle.
in_ready  output  1  the block accepts a sample this cycle.
carry  input  1  adder carry-out, forms the sample MSB.
sum  input  BITS  adder sum, forms the sample LSBs.
flush  input  1  synchronous request to discard the partial batch.
out_valid  output  1  batch total is available.
out_ready  input  1  downstream accepts the total.
out_total  output  ACC_BITS  accumulated batch total.
out_overflow  output  1  batch saturated; valid while out_valid is high.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Ports are named clock and reset.
- Reset values (asynchronous, immediate): state=ACCUM, acc=0, cnt=0, out_valid=0, out_total=0, out_overflow=0. in_ready reads 1 after reset, provided flush is low.
- Sample: the zero-extended concatenation {carry, sum}, range 0 to 2^(BITS+1)-1.
- Accept: an input transfer happens when in_valid and in_ready are both high at a rising edge.
- Release: an output transfer happens when out_valid and out_ready are both high at a rising edge.
- in_ready is combinational: (state==ACCUM) and not flush.
- out_valid is (state==HOLD), registered.
- out_total and out_overflow are registered and driven from acc and ovf.
- State ACCUM:
  - On accept: acc <= sat(acc + sample) and cnt <= cnt+1.
  - ovf is set if the true sum exceeds 2^ACC_BITS-1; acc then holds all-ones.
  - If the accepted sample has cnt==NUM_SAMPLES-1: go to HOLD on that edge, so out_valid is high the next cycle. Latency from the final accept to out_valid is 1 cycle.
- ACCUM with flush: acc, cnt and ovf are cleared next edge. No sample is accepted that cycle because in_ready is low.
- State HOLD:
  - in_ready=0, so in_valid is ignored.
  - out_total and out_overflow stay stable until release.
  - flush is ignored.
  - On release: go to ACCUM and clear acc, cnt and ovf. in_ready is high the next cycle.
  - There is no back-to-back overlap: there is at least 1 cycle between release and the next accept edge.
- cnt width is clog2(NUM_SAMPLES). cnt wraps to 0 only through the HOLD release or flush, never by overflow.
- Overflow is sticky within a batch. Once saturated, acc stays all-ones for the rest of the batch.
- Reset asserted mid-batch or in HOLD: the partial or pending result is lost with no output transfer. After reset release, the batch starts from zero.
- Illegal parameters (ACC_BITS<BITS+1, NUM_SAMPLES<2) are caught by an elaboration-time assertion.

Decomposition:
- Package sum_collector_pkg holds:
  - typedef enum logic {ACCUM, HOLD} collector_state_t;
  - the function for the clog2-based counter width.
- One combinational sub-module, sat_accumulate, parameterised by BITS and ACC_BITS.
  - Inputs: acc, sample.
  - Outputs: next_acc, ovf_hit.
  - Reused by later batching stages.

Test Plan:
1. Defaults. Reset, then 8 back-to-back samples of carry=0, sum=3 with out_ready=1 -> out_valid high exactly 1 cycle after the 8th accept, out_total=24, out_overflow=0, in_ready=1 the cycle after release.
2. Defaults. 8 samples of carry=1, sum=15 -> out_total=248, out_overflow=0. Instance with ACC_BITS=7, same stimulus -> out_total=127, out_overflow=1.
3. out_ready held low 5 cycles after out_valid, with in_valid pulsing -> out_total and out_valid stable, in_ready=0, no sample counted. After out_ready=1, the next batch of 8 samples of 1 gives 8.
4. 8 samples of 5 delivered with in_valid alternating 1/0 -> out_total=40, out_valid 1 cycle after the 8th accept.
5. 3 samples of 7, then flush for 1 cycle with in_valid=1 -> that cycle's sample is not accepted. A following 8 samples of 1 give out_total=8.
6. Async reset pulsed between clock edges after 5 samples of 9 -> out_valid/out_total/out_overflow are 0 before the next edge. A subsequent 8 samples of 2 give out_total=16.
